// File: rtl/hart.sv
// Single-cycle RV32I hart: one instruction fetched, executed and retired per clock,
// with a retire port describing every instruction as it completes.
module hart #(
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_imem_raddr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_dmem_addr,
  output logic        o_dmem_ren,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_mask,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_retire_valid,
  output logic [31:0] o_retire_inst,
  output logic        o_retire_trap,
  output logic        o_retire_halt,
  output logic [4:0]  o_retire_rs1_raddr,
  output logic [4:0]  o_retire_rs2_raddr,
  output logic [31:0] o_retire_rs1_rdata,
  output logic [31:0] o_retire_rs2_rdata,
  output logic [4:0]  o_retire_rd_waddr,
  output logic [31:0] o_retire_rd_wdata,
  output logic [31:0] o_retire_pc,
  output logic [31:0] o_retire_next_pc
);

  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;

  logic [31:0] inst;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_data, rs2_data, pc_plus4, mem_addr, shifted, load_val;
  logic [31:0] rd_val, target, next_pc;
  logic [3:0]  lane_mask;
  logic        illegal, misaligned, trap, rd_we, is_load, is_store, is_ebreak, taken;
  logic        active, commit, rf_we, mem_ok;

  assign inst     = i_imem_rdata;
  assign opcode   = inst[6:0];
  assign funct3   = inst[14:12];
  assign funct7   = inst[31:25];
  assign imm_i    = {{20{inst[31]}}, inst[31:20]};
  assign imm_s    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u    = {inst[31:12], 12'b0};
  assign imm_j    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;
  assign mem_addr = rs1_data + ((opcode == 7'b0100011) ? imm_s : imm_i);

  hart_rf rf (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rs1_addr (inst[19:15]),
    .i_rs2_addr (inst[24:20]),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .i_we       (rf_we),
    .i_waddr    (inst[11:7]),
    .i_wdata    (rd_val)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu = {31'b0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  // Load lane extraction: shift the addressed byte/halfword down to bit 0.
  always_comb begin
    shifted = i_dmem_rdata >> {mem_addr[1:0], 3'b000};
    case (funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'b0, shifted[7:0]};
      3'b101:  load_val = {16'b0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    illegal   = 1'b0;
    rd_we     = 1'b0;
    rd_val    = '0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_ebreak = 1'b0;
    taken     = 1'b0;
    target    = pc_q + imm_b;
    case (opcode)
      7'b0110111: begin rd_we = 1'b1; rd_val = imm_u; end
      7'b0010111: begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
      7'b1101111: begin
        rd_we = 1'b1; rd_val = pc_plus4; taken = 1'b1; target = pc_q + imm_j;
      end
      7'b1100111: begin
        illegal = (funct3 != 3'b000);
        rd_we = 1'b1; rd_val = pc_plus4; taken = 1'b1;
        target = (rs1_data + imm_i) & ~32'd1;
      end
      7'b1100011: begin
        case (funct3)
          3'b000:  taken = (rs1_data == rs2_data);
          3'b001:  taken = (rs1_data != rs2_data);
          3'b100:  taken = ($signed(rs1_data) < $signed(rs2_data));
          3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
          3'b110:  taken = (rs1_data < rs2_data);
          3'b111:  taken = (rs1_data >= rs2_data);
          default: illegal = 1'b1;
        endcase
      end
      7'b0000011: begin
        is_load = 1'b1; rd_we = 1'b1; rd_val = load_val;
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      7'b0100011: begin
        is_store = 1'b1;
        illegal = funct3[2] || (funct3[1:0] == 2'b11);
      end
      7'b0010011: begin
        illegal = ((funct3 == 3'b001) && (funct7 != 7'h00)) ||
                  ((funct3 == 3'b101) && (funct7 != 7'h00) && (funct7 != 7'h20));
        rd_we = 1'b1;
        rd_val = alu(rs1_data, imm_i, funct3, (funct3 == 3'b101) && inst[30]);
      end
      7'b0110011: begin
        illegal = !((funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        rd_we = 1'b1;
        rd_val = alu(rs1_data, rs2_data, funct3, inst[30]);
      end
      7'b0001111: illegal = (funct3 != 3'b000);
      7'b1110011: begin
        if (inst == 32'h00100073) is_ebreak = 1'b1;
        else if (inst != 32'h00000073) illegal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Alignment faults only count for accesses and control transfers that actually happen.
  always_comb begin
    misaligned = 1'b0;
    lane_mask  = 4'b1111;
    if (is_load || is_store) begin
      case (funct3[1:0])
        2'b00:   lane_mask = 4'b0001 << mem_addr[1:0];
        2'b01:   begin lane_mask = 4'b0011 << mem_addr[1:0]; misaligned = mem_addr[0]; end
        default: misaligned = |mem_addr[1:0];
      endcase
    end
    if (taken && (|target[1:0])) misaligned = 1'b1;
  end

  assign trap    = illegal || misaligned;
  assign active  = !i_rst && !halted_q;
  assign commit  = active && !trap && !is_ebreak;
  assign rf_we   = commit && rd_we && (inst[11:7] != 5'd0);
  assign mem_ok  = active && !trap;
  assign next_pc = (trap || is_ebreak) ? pc_q : (taken ? target : pc_plus4);

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    if (active) begin
      pc_d     = next_pc;
      halted_d = trap || is_ebreak;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q     <= RESET_ADDR;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  assign o_imem_raddr       = pc_q;
  assign o_dmem_addr        = {mem_addr[31:2], 2'b00};
  assign o_dmem_ren         = mem_ok && is_load;
  assign o_dmem_wen         = mem_ok && is_store;
  assign o_dmem_wdata       = rs2_data << {mem_addr[1:0], 3'b000};
  assign o_dmem_mask        = (o_dmem_ren || o_dmem_wen) ? lane_mask : 4'b0000;
  assign o_retire_valid     = active;
  assign o_retire_inst      = inst;
  assign o_retire_trap      = active && trap;
  assign o_retire_halt      = !i_rst && (halted_q || trap || is_ebreak);
  assign o_retire_rs1_raddr = inst[19:15];
  assign o_retire_rs2_raddr = inst[24:20];
  assign o_retire_rs1_rdata = rs1_data;
  assign o_retire_rs2_rdata = rs2_data;
  assign o_retire_rd_waddr  = rf_we ? inst[11:7] : 5'd0;
  assign o_retire_rd_wdata  = rf_we ? rd_val : 32'd0;
  assign o_retire_pc        = pc_q;
  assign o_retire_next_pc   = active ? next_pc : pc_q;

endmodule

// Architectural register file; x0 is forced to zero on read.
module hart_rf (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] mem [0:31];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? 32'd0 : mem[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? 32'd0 : mem[i_rs2_addr];

endmodule

// File: tb/tb_hart.sv
// Bench for the single-cycle hart: small programs with expected retire records,
// pushed to a scoreboard at load time and popped as each instruction retires.
module tb_hart;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] o_imem_raddr, i_imem_rdata;
  logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
  logic        o_dmem_ren, o_dmem_wen;
  logic [3:0]  o_dmem_mask;
  logic        o_retire_valid, o_retire_trap, o_retire_halt;
  logic [31:0] o_retire_inst, o_retire_rs1_rdata, o_retire_rs2_rdata;
  logic [4:0]  o_retire_rs1_raddr, o_retire_rs2_raddr, o_retire_rd_waddr;
  logic [31:0] o_retire_rd_wdata, o_retire_pc, o_retire_next_pc;

  always #5 i_clk = ~i_clk;

  hart dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_imem_raddr(o_imem_raddr), .i_imem_rdata(i_imem_rdata),
    .o_dmem_addr(o_dmem_addr), .o_dmem_ren(o_dmem_ren), .o_dmem_wen(o_dmem_wen),
    .o_dmem_wdata(o_dmem_wdata), .o_dmem_mask(o_dmem_mask), .i_dmem_rdata(i_dmem_rdata),
    .o_retire_valid(o_retire_valid), .o_retire_inst(o_retire_inst),
    .o_retire_trap(o_retire_trap), .o_retire_halt(o_retire_halt),
    .o_retire_rs1_raddr(o_retire_rs1_raddr), .o_retire_rs2_raddr(o_retire_rs2_raddr),
    .o_retire_rs1_rdata(o_retire_rs1_rdata), .o_retire_rs2_rdata(o_retire_rs2_rdata),
    .o_retire_rd_waddr(o_retire_rd_waddr), .o_retire_rd_wdata(o_retire_rd_wdata),
    .o_retire_pc(o_retire_pc), .o_retire_next_pc(o_retire_next_pc)
  );

  // Instruction and data memories, both combinational read; data writes land on the edge.
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic        dmem_clear = 1'b1;

  assign i_imem_rdata = imem[o_imem_raddr[7:2]];
  assign i_dmem_rdata = dmem[o_dmem_addr[7:2]];

  always @(posedge i_clk) begin
    if (dmem_clear) begin
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
    end else if (o_dmem_wen) begin
      for (int b = 0; b < 4; b++)
        if (o_dmem_mask[b]) dmem[o_dmem_addr[7:2]][8*b +: 8] <= o_dmem_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] next_pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        trap;
    logic        halt;
    logic        ren;
    logic        wen;
    logic [3:0]  mask;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          prog_first[$];
  int          prog_cnt[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] cur_pc   = '0;

  // Instruction encoders
  function automatic logic [31:0] ei(int imm, int rs1, int f3, int rd, int op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] es(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] eb(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] eu(int imm, int rd, int op);
    return {imm[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] ej(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] er(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  // Record builders: register/flow op, memory op, and halting op (trap or ebreak)
  function automatic vec_t vr(logic [31:0] pc, logic [31:0] inst, logic [31:0] npc,
                              int rd, logic [31:0] wdata);
    vec_t v;
    v.pc = pc; v.inst = inst; v.next_pc = npc; v.rd = rd[4:0]; v.wdata = wdata;
    v.trap = 1'b0; v.halt = 1'b0; v.ren = 1'b0; v.wen = 1'b0; v.mask = 4'b0;
    v.maddr = '0; v.mwdata = '0;
    return v;
  endfunction
  function automatic vec_t vm(logic [31:0] pc, logic [31:0] inst, int rd, logic [31:0] wdata,
                              int ren, int wen, int mask, logic [31:0] maddr, logic [31:0] mwdata);
    vec_t v;
    v = vr(pc, inst, pc + 32'd4, rd, wdata);
    v.ren = ren[0]; v.wen = wen[0]; v.mask = mask[3:0]; v.maddr = maddr; v.mwdata = mwdata;
    return v;
  endfunction
  function automatic vec_t vt(logic [31:0] pc, logic [31:0] inst, int trap);
    vec_t v;
    v = vr(pc, inst, pc, 0, 32'd0);
    v.trap = trap[0]; v.halt = 1'b1;
    return v;
  endfunction

  task automatic chk32(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s @pc %h: got %h expected %h", name, cur_pc, got, exp);
  endtask
  task automatic chk1(string name, logic got, logic exp);
    chk32(name, {31'b0, got}, {31'b0, exp});
  endtask

  // Load a program, clear data memory, and hold reset for two edges
  task automatic applyStimulus(int first, int cnt);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    dmem_clear = 1'b1;
    for (int i = 0; i < 64; i++) imem[i] = 32'hffffffff;
    for (int k = 0; k < cnt; k++) begin
      imem[vecs[first+k].pc[7:2]] = vecs[first+k].inst;
      exp_q.push_back(vecs[first+k]);
    end
    @(posedge i_clk); #1;
    @(negedge i_clk);
    cur_pc = 32'd0;
    chk1("rst_valid", o_retire_valid, 1'b0);
    chk1("rst_trap", o_retire_trap, 1'b0);
    chk1("rst_halt", o_retire_halt, 1'b0);
    chk1("rst_ren", o_dmem_ren, 1'b0);
    chk1("rst_wen", o_dmem_wen, 1'b0);
    chk32("rst_pc", o_imem_raddr, 32'h0);
    chk32("rst_a0", dut.rf.mem[10], 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    dmem_clear = 1'b0;
  endtask

  task automatic checkOutput(vec_t e);
    cur_pc = e.pc;
    chk1("valid", o_retire_valid, 1'b1);
    chk32("pc", o_retire_pc, e.pc);
    chk32("inst", o_retire_inst, e.inst);
    chk32("next_pc", o_retire_next_pc, e.next_pc);
    chk32("rs1_raddr", {27'b0, o_retire_rs1_raddr}, {27'b0, e.inst[19:15]});
    chk32("rd_waddr", {27'b0, o_retire_rd_waddr}, {27'b0, e.rd});
    chk32("rd_wdata", o_retire_rd_wdata, e.wdata);
    chk1("trap", o_retire_trap, e.trap);
    chk1("halt", o_retire_halt, e.halt);
    chk1("ren", o_dmem_ren, e.ren);
    chk1("wen", o_dmem_wen, e.wen);
    chk32("mask", {28'b0, o_dmem_mask}, {28'b0, e.mask});
    if (e.ren || e.wen) chk32("dmem_addr", o_dmem_addr, e.maddr);
    if (e.wen) chk32("dmem_wdata", o_dmem_wdata, e.mwdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t cur;
    int   start;
    logic [31:0] last_pc;

    // Program 0: addi chain and ebreak
    start = vecs.size();
    vecs.push_back(vr(32'h0, ei(5, 0, 0, 10, 'h13), 32'h4, 10, 32'h5));
    vecs.push_back(vr(32'h4, ei(-7, 10, 0, 11, 'h13), 32'h8, 11, 32'hfffffffe));
    vecs.push_back(vt(32'h8, 32'h00100073, 0));
    prog_first.push_back(start); prog_cnt.push_back(vecs.size() - start);

    // Program 1: loads and stores across byte lanes
    start = vecs.size();
    vecs.push_back(vr(32'h0, eu('h12345, 5, 'h37), 32'h4, 5, 32'h12345000));
    vecs.push_back(vr(32'h4, ei('h678, 5, 0, 5, 'h13), 32'h8, 5, 32'h12345678));
    vecs.push_back(vm(32'h8, es(4, 5, 0, 2), 0, 32'h0, 0, 1, 'hf, 32'h4, 32'h12345678));
    vecs.push_back(vm(32'hc, ei(5, 0, 0, 6, 3), 6, 32'h56, 1, 0, 'h2, 32'h4, 32'h0));
    vecs.push_back(vm(32'h10, ei(6, 0, 5, 7, 3), 7, 32'h1234, 1, 0, 'hc, 32'h4, 32'h0));
    vecs.push_back(vr(32'h14, ei('hab, 0, 0, 28, 'h13), 32'h18, 28, 32'hab));
    vecs.push_back(vm(32'h18, es(7, 28, 0, 0), 0, 32'h0, 0, 1, 'h8, 32'h4, 32'hab000000));
    vecs.push_back(vm(32'h1c, ei(4, 0, 2, 29, 3), 29, 32'hab345678, 1, 0, 'hf, 32'h4, 32'h0));
    vecs.push_back(vm(32'h20, ei(7, 0, 0, 30, 3), 30, 32'hffffffab, 1, 0, 'h8, 32'h4, 32'h0));
    vecs.push_back(vt(32'h24, 32'h00100073, 0));
    prog_first.push_back(start); prog_cnt.push_back(vecs.size() - start);

    // Program 2: branches and jumps
    start = vecs.size();
    vecs.push_back(vr(32'h0, ei(1, 0, 0, 10, 'h13), 32'h4, 10, 32'h1));
    vecs.push_back(vr(32'h4, eb(8, 0, 10, 1), 32'hc, 0, 32'h0));
    vecs.push_back(vr(32'hc, ei(2, 0, 0, 11, 'h13), 32'h10, 11, 32'h2));
    vecs.push_back(vr(32'h10, ej(16, 1), 32'h20, 1, 32'h14));
    vecs.push_back(vr(32'h20, ei(1, 1, 0, 0, 'h67), 32'h14, 0, 32'h0));
    vecs.push_back(vr(32'h14, eb(100, 0, 10, 0), 32'h18, 0, 32'h0));
    vecs.push_back(vt(32'h18, 32'h00100073, 0));
    prog_first.push_back(start); prog_cnt.push_back(vecs.size() - start);

    // Program 3: compare, shift and x0 corner cases
    start = vecs.size();
    vecs.push_back(vr(32'h0, ei(-1, 0, 0, 5, 'h13), 32'h4, 5, 32'hffffffff));
    vecs.push_back(vr(32'h4, ei(1, 0, 0, 6, 'h13), 32'h8, 6, 32'h1));
    vecs.push_back(vr(32'h8, er(0, 6, 5, 2, 7), 32'hc, 7, 32'h1));
    vecs.push_back(vr(32'hc, er(0, 6, 5, 3, 28), 32'h10, 28, 32'h0));
    vecs.push_back(vr(32'h10, eu('h80000, 29, 'h37), 32'h14, 29, 32'h80000000));
    vecs.push_back(vr(32'h14, ei('h404, 29, 5, 30, 'h13), 32'h18, 30, 32'hf8000000));
    vecs.push_back(vr(32'h18, ei(1, 0, 0, 0, 'h13), 32'h1c, 0, 32'h0));
    vecs.push_back(vr(32'h1c, er('h20, 5, 6, 0, 8), 32'h20, 8, 32'h2));
    vecs.push_back(vr(32'h20, ei(28, 5, 5, 9, 'h13), 32'h24, 9, 32'hf));
    vecs.push_back(vt(32'h24, 32'h00100073, 0));
    prog_first.push_back(start); prog_cnt.push_back(vecs.size() - start);

    // Program 4: misaligned lw traps; run twice to show reset from the halted state
    start = vecs.size();
    vecs.push_back(vr(32'h0, ei(3, 0, 0, 10, 'h13), 32'h4, 10, 32'h3));
    vecs.push_back(vt(32'h4, ei(2, 0, 2, 11, 3), 1));
    prog_first.push_back(start); prog_cnt.push_back(vecs.size() - start);
    prog_first.push_back(start); prog_cnt.push_back(vecs.size() - start);

    // Program 5: illegal instruction word
    start = vecs.size();
    vecs.push_back(vt(32'h0, 32'hffffffff, 1));
    prog_first.push_back(start); prog_cnt.push_back(vecs.size() - start);

    // Program 6: jal to a misaligned target
    start = vecs.size();
    vecs.push_back(vr(32'h0, ei(7, 0, 0, 10, 'h13), 32'h4, 10, 32'h7));
    vecs.push_back(vt(32'h4, ej(6, 1), 1));
    prog_first.push_back(start); prog_cnt.push_back(vecs.size() - start);

    for (int p = 0; p < prog_first.size(); p++) begin
      $display("[TB] program %0d", p);
      applyStimulus(prog_first[p], prog_cnt[p]);
      last_pc = 32'h0;
      while (exp_q.size() > 0) begin
        @(negedge i_clk);
        cur = exp_q.pop_front();
        last_pc = cur.pc;
        checkOutput(cur);
      end
      // One more cycle: the hart must stay frozen
      @(negedge i_clk);
      cur_pc = last_pc;
      chk1("halted_valid", o_retire_valid, 1'b0);
      chk1("halted_halt", o_retire_halt, 1'b1);
      chk1("halted_ren", o_dmem_ren, 1'b0);
      chk1("halted_wen", o_dmem_wen, 1'b0);
      chk32("halted_pc", o_imem_raddr, last_pc);
      if (p == 0) begin
        chk32("rf_a0", dut.rf.mem[10], 32'h5);
        chk32("rf_a1", dut.rf.mem[11], 32'hfffffffe);
      end
      if (p == 1) chk32("dmem_word1", dmem[1], 32'hab345678);
      if (p == 2) chk32("rf_ra", dut.rf.mem[1], 32'h14);
      if (p == 4 || p == 5) begin
        chk32("trap_a0", dut.rf.mem[10], 32'h3);
        chk32("trap_a1", dut.rf.mem[11], 32'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hart.md
# hart

Single-cycle RV32I hart: fetches, decodes, executes and retires one instruction per clock from separate instruction and data memory ports. It sits at the top of the processor datapath. It exposes a per-instruction retire interface, used by benches for tracing and checking. The register file instance is named `rf`, with storage array `mem[0:31]`, so benches can read architectural registers hierarchically (e.g. `rf.mem[10]` = a0).

## Interface
- `RESET_ADDR`, default `32'h0`: PC value loaded on reset.

- `i_clk` in 1: clock; all state updates on rising edge.
- `i_rst` in 1: reset, synchronous, active-high.
- `o_imem_raddr` out 32: fetch address (= current PC).
- `i_imem_rdata` in 32: instruction word, combinational from imem.
- `o_dmem_addr` out 32: data address, word-aligned (`addr & ~3`).
- `o_dmem_ren` out 1: load in progress this cycle.
- `o_dmem_wen` out 1: store commits at next rising edge.
- `o_dmem_wdata` out 32: store data shifted into byte lanes.
- `o_dmem_mask` out 4: byte-lane enables for loads and stores, little-endian.
- `i_dmem_rdata` in 32: full aligned word, combinational.
- `o_retire_valid` out 1: an instruction retires this cycle.
- `o_retire_inst` out 32: retired instruction word.
- `o_retire_trap` out 1: retired instruction trapped.
- `o_retire_halt` out 1: hart halted (ebreak or trap).
- `o_retire_rs1_raddr` / `o_retire_rs2_raddr` out 5: `inst[19:15]` / `inst[24:20]`.
- `o_retire_rs1_rdata` / `o_retire_rs2_rdata` out 32: register values read.
- `o_retire_rd_waddr` out 5: `inst[11:7]` if the instruction writes rd, else 0.
- `o_retire_rd_wdata` out 32: value written; 0 when rd_waddr = 0.
- `o_retire_pc` out 32: PC of the retired instruction.
- `o_retire_next_pc` out 32: PC of the next instruction.

## Operation
- Implements the full RV32I base: LUI, AUIPC, JAL, JALR, the branches, loads LB/LH/LW/LBU/LHU, stores SB/SH/SW, OP-IMM, OP, FENCE (no-op), ECALL (no-op), EBREAK.
- All arithmetic is mod 2^32. SLT uses signed compare; SLTU uses unsigned. Shift amount is the low 5 bits. SRA is arithmetic.
- x0 reads 0; writes to x0 are discarded, and rd_waddr reports 0 for them.
- JALR target is `(rs1+imm) & ~1`.
- Loads select the byte/halfword from the lane given by `addr[1:0]` and sign- or zero-extend it.
- Store masks: SB = `0001 << addr[1:0]`, SH = `0011 << addr[1:0]`, SW = `1111`.
- When no load or store is active: ren = 0, wen = 0, mask = 0.
- Traps (trap=1, halt=1, no register or memory write, PC holds):
  - unknown opcode or funct encoding;
  - misaligned LH/LHU/SH (`addr[0]`);
  - misaligned LW/SW (`addr[1:0] != 0`);
  - taken jump or branch target with `target[1:0] != 0`.
- EBREAK: retires with halt=1, trap=0, no writeback.
- Once halted, the hart freezes until reset:
  - PC holds, no register or memory writes;
  - valid=0, halt stays 1;
  - ren and wen stay 0.

## Timing
- Fully single-cycle. Fetch, decode, execute, memory and writeback are combinational within one cycle; the retire outputs describe that same instruction.
- PC, the register file, the halted flag and dmem writes update at the rising edge.
- Load data arrives combinationally in the same cycle.
- Register-file read occurs before write: a same-cycle rs1 = rd instruction reads the old value.
- Reset (any cycle, including mid-program or while halted) takes effect at the rising edge:
  - PC = RESET_ADDR;
  - all 32 registers = 0;
  - halted = 0.
- While `i_rst`=1: valid=0, trap=0, halt=0, ren=0, wen=0; rd_waddr is not written.
- The first instruction retires in the first cycle after `i_rst` falls.
- In every non-reset, non-halted cycle, valid=1.
- `next_pc`:
  - pc+4 by default;
  - branch/jump target when taken;
  - pc on trap or EBREAK.

## Test plan
- `addi a0,x0,5; addi a1,a0,-7; ebreak` → w[a0]=00000005, then w[a1]=fffffffe. Halt on the third retire, next_pc = pc. `rf.mem[10]`=5.
- `lui t0,0x12345; addi t0,t0,0x678; sw t0,4(x0); lb t1,5(x0); lhu t2,6(x0)` →
  - store: addr 4, mask 1111, data 12345678;
  - lb: mask 0010, t1=00000056;
  - lhu: mask 1100, t2=00001234.
- `sb` of 0xAB to address 7 → addr 4, mask 1000, wdata ab000000; bytes 4–6 are unchanged.
- Branch/jump:
  - `bne` taken with offset +8 → next_pc = pc+8;
  - `jal ra,16` at pc 0x10 → ra=00000014, next_pc=0x20;
  - `jalr x0,1(ra)` → target LSB cleared.
- Arithmetic: `slt`/`sltu` with 0xffffffff vs 1 → 1 / 0; `srai` of 0x80000000 by 4 → f8000000; `addi x0,x0,1` → rd_waddr 0.
- Traps:
  - `lw` from address 2 → trap=1, halt=1, no rd write, then valid=0;
  - illegal word 0xffffffff → trap;
  - assert reset afterwards → PC = RESET_ADDR, registers zero, execution resumes.
